// File: rtl/seg7_pattern_decoder.sv
// rtl/seg7_pattern_decoder.sv - recovers hex digits from 7-segment drive words, reports changes on an update stream
// Optional macro SEG7_SYNC_EN puts a 2-flop synchronizer on every seg_in bit ahead of the sample register.
module seg7_pattern_decoder #(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [8*NUM_DIGITS-1:0] seg_in,
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   lane_ok,
  output logic [NUM_DIGITS-1:0]   bad_pat,
  output logic                    upd_valid,
  input  logic                    upd_ready,
  output logic [NUM_DIGITS-1:0]   upd_mask,
  output logic                    overrun
);

  localparam logic [7:0] CNT_SAT = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_ACC = (STABLE_CYCLES >= 2) ? 8'(STABLE_CYCLES - 2) : 8'd0;

  typedef enum logic {IDLE, PEND} state_t;

  state_t                  state, state_nxt;
  logic [8*NUM_DIGITS-1:0] samp_d, samp, prev;
  logic [7:0]              cnt     [NUM_DIGITS];
  logic [7:0]              cnt_nxt [NUM_DIGITS];
  logic [4:0]              dec     [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   acc, good, chg, ok_nxt, bad_nxt, mask_nxt;
  logic [4*NUM_DIGITS-1:0] hex_nxt;
  logic                    ovr_nxt;

  // {recognised, digit}
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: return 5'h10;
      7'h09: return 5'h11;
      7'h5E: return 5'h12;
      7'h5B: return 5'h13;
      7'h69: return 5'h14;
      7'h73: return 5'h15;
      7'h77: return 5'h16;
      7'h19: return 5'h17;
      7'h7F: return 5'h18;
      7'h79: return 5'h19;
      7'h7D: return 5'h1A;
      7'h67: return 5'h1B;
      7'h36: return 5'h1C;
      7'h4F: return 5'h1D;
      7'h76: return 5'h1E;
      7'h74: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

`ifdef SEG7_SYNC_EN
  logic [8*NUM_DIGITS-1:0] sync1, sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= seg_in;
      sync2 <= sync1;
    end
  end

  assign samp_d = sync2;
`else
  assign samp_d = seg_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp <= '0;
      prev <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) cnt[k] <= '0;
    end else begin
      samp <= samp_d;
      prev <= samp;
      for (int k = 0; k < NUM_DIGITS; k++) cnt[k] <= cnt_nxt[k];
    end
  end

  // cnt only passes CNT_ACC once per stable run, so a held word is accepted exactly once
  always_comb begin
    acc     = '0;
    good    = '0;
    chg     = '0;
    ok_nxt  = lane_ok;
    bad_nxt = bad_pat;
    hex_nxt = hex_out;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      dec[k]     = decode(samp[8*k+1 +: 7]);
      good[k]    = dec[k][4] && !samp[8*k];
      cnt_nxt[k] = cnt[k];
      if (samp[8*k +: 8] != prev[8*k +: 8]) cnt_nxt[k] = '0;
      else if (cnt[k] != CNT_SAT)           cnt_nxt[k] = cnt[k] + 8'd1;
      acc[k] = (samp[8*k +: 8] == prev[8*k +: 8]) && (cnt[k] == CNT_ACC);
      if (acc[k]) begin
        ok_nxt[k]  = good[k];
        bad_nxt[k] = !good[k];
        if (good[k]) begin
          hex_nxt[4*k +: 4] = dec[k][3:0];
          chg[k] = !(lane_ok[k] && (hex_out[4*k +: 4] == dec[k][3:0]));
        end else begin
          chg[k] = !bad_pat[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_out <= '0;
      lane_ok <= '0;
      bad_pat <= '0;
    end else begin
      hex_out <= hex_nxt;
      lane_ok <= ok_nxt;
      bad_pat <= bad_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      upd_mask <= '0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      upd_mask <= mask_nxt;
      overrun  <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mask_nxt  = upd_mask;
    ovr_nxt   = overrun;
    case (state)
      IDLE: begin
        if (|chg) begin
          state_nxt = PEND;
          mask_nxt  = chg;
        end
      end
      PEND: begin
        if (upd_ready) begin
          if (|chg) begin
            mask_nxt = chg;
          end else begin
            state_nxt = IDLE;
            mask_nxt  = '0;
          end
        end else if (|chg) begin
          mask_nxt = upd_mask | chg;
          ovr_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign upd_valid = (state == PEND);

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// tb/tb_seg7_pattern_decoder.sv - self-checking bench for seg7_pattern_decoder
// Honours SEG7_SYNC_EN: filter latency grows by 2 clk when defined.
module tb_seg7_pattern_decoder;

  localparam int N      = 8;
  localparam int STABLE = 4;
`ifdef SEG7_SYNC_EN
  localparam int PIPE = 3;
`else
  localparam int PIPE = 1;
`endif
  localparam int LAT = STABLE + PIPE;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [8*N-1:0] seg_in;
  logic [4*N-1:0] hex_out;
  logic [N-1:0]   lane_ok, bad_pat, upd_mask;
  logic           upd_valid, upd_ready, overrun;

  always #5 clk = ~clk;

  seg7_pattern_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .hex_out(hex_out),
    .lane_ok(lane_ok), .bad_pat(bad_pat), .upd_valid(upd_valid),
    .upd_ready(upd_ready), .upd_mask(upd_mask), .overrun(overrun)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_upd, n_badmask;
  logic cnt_en = 1'b0;
  logic saw_valid = 1'b0;

  logic [6:0] pat_tab [16] = '{7'h3F, 7'h09, 7'h5E, 7'h5B, 7'h69, 7'h73, 7'h77, 7'h19,
                               7'h7F, 7'h79, 7'h7D, 7'h67, 7'h36, 7'h4F, 7'h76, 7'h74};

  // Reference: the filter sees seg_in delayed by PIPE clocks; a lane is accepted
  // when a run of identical samples reaches exactly STABLE long.
  logic [7:0]     pipe    [N][PIPE];
  logic [7:0]     run_val [N];
  int             run_len [N];
  logic [4*N-1:0] m_hex;
  logic [N-1:0]   m_ok, m_bad, m_mask;
  logic           m_pend, m_ovr;

  typedef struct {
    logic [7:0] word;
    logic [3:0] hex;
    logic       ok;
  } vec_t;
  vec_t vecs [18];

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < PIPE; j++) pipe[k][j] = 8'h00;
      run_val[k] = 8'h00;
      run_len[k] = 1;
    end
    m_hex = '0; m_ok = '0; m_bad = '0; m_mask = '0; m_pend = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_step();
    logic [N-1:0] chg;
    logic [7:0]   w;
    logic [5:0]   old_t, new_t;
    int           digit;
    if (!rst_n) begin
      model_reset();
      return;
    end
    chg = '0;
    for (int k = 0; k < N; k++) begin
      w = pipe[k][PIPE-1];
      if (w == run_val[k]) begin
        if (run_len[k] < 1000) run_len[k]++;
      end else begin
        run_val[k] = w;
        run_len[k] = 1;
      end
      if (run_len[k] == STABLE) begin
        digit = -1;
        for (int i = 0; i < 16; i++) if (pat_tab[i] == w[7:1]) digit = i;
        old_t = {m_ok[k], m_bad[k], m_hex[4*k +: 4]};
        if (digit >= 0 && w[0] == 1'b0) new_t = {2'b10, 4'(digit)};
        else                             new_t = {2'b01, m_hex[4*k +: 4]};
        chg[k] = (new_t != old_t);
        {m_ok[k], m_bad[k], m_hex[4*k +: 4]} = new_t;
      end
      for (int j = PIPE - 1; j > 0; j--) pipe[k][j] = pipe[k][j-1];
      pipe[k][0] = seg_in[8*k +: 8];
    end
    if (!m_pend) begin
      if (chg != 0) begin m_pend = 1'b1; m_mask = chg; end
    end else if (upd_ready) begin
      if (chg != 0) m_mask = chg;
      else begin m_pend = 1'b0; m_mask = '0; end
    end else if (chg != 0) begin
      m_mask = m_mask | chg;
      m_ovr  = 1'b1;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("cycle", {hex_out, lane_ok, bad_pat, upd_valid, upd_mask, overrun},
                   {m_hex, m_ok, m_bad, m_pend, m_mask, m_ovr});
    if (upd_valid) saw_valid = 1'b1;
    if (cnt_en && upd_valid && upd_ready) begin
      n_upd++;
      if (upd_mask != 8'h01) n_badmask++;
    end
    #1;
  endtask

  initial begin
    int lane, r, waited;
    vecs[0]  = '{8'h7E, 4'h0, 1'b1}; vecs[1]  = '{8'h12, 4'h1, 1'b1};
    vecs[2]  = '{8'hBC, 4'h2, 1'b1}; vecs[3]  = '{8'hB6, 4'h3, 1'b1};
    vecs[4]  = '{8'hD2, 4'h4, 1'b1}; vecs[5]  = '{8'hE6, 4'h5, 1'b1};
    vecs[6]  = '{8'hEE, 4'h6, 1'b1}; vecs[7]  = '{8'h32, 4'h7, 1'b1};
    vecs[8]  = '{8'hFE, 4'h8, 1'b1}; vecs[9]  = '{8'hF2, 4'h9, 1'b1};
    vecs[10] = '{8'hFA, 4'hA, 1'b1}; vecs[11] = '{8'hCE, 4'hB, 1'b1};
    vecs[12] = '{8'h6C, 4'hC, 1'b1}; vecs[13] = '{8'h9E, 4'hD, 1'b1};
    vecs[14] = '{8'hEC, 4'hE, 1'b1}; vecs[15] = '{8'hE8, 4'hF, 1'b1};
    vecs[16] = '{8'h7F, 4'hF, 1'b0}; vecs[17] = '{8'h02, 4'hF, 1'b0};

    rst_n = 1'b0;
    seg_in = {N{8'hE8}};
    upd_ready = 1'b1;
    model_reset();
    repeat (2) tick();
    check("reset_outputs", {hex_out, lane_ok, bad_pat, upd_valid, upd_mask, overrun}, 64'h0);
    rst_n = 1'b1;
    repeat (LAT + 4) tick();
    check("init_lock", {hex_out, lane_ok}, {32'hFFFF_FFFF, 8'hFF});

    // decode sweep on lane0
    n_upd = 0; n_badmask = 0; cnt_en = 1'b1;
    for (int i = 0; i < 18; i++) begin
      seg_in[7:0] = vecs[i].word;
      repeat (10) tick();
      check($sformatf("sweep[%0d]", i), {hex_out[3:0], lane_ok[0], bad_pat[0]},
            {vecs[i].hex, vecs[i].ok, !vecs[i].ok});
      if (i == 15) cnt_en = 1'b0;
    end
    check("sweep_updates", n_upd, 16);
    check("sweep_mask", n_badmask, 0);

    // glitch shorter than the filter window
    seg_in[7:0] = 8'hB6;
    repeat (10) tick();
    saw_valid = 1'b0;
    seg_in[7:0] = 8'hFE;
    repeat (2) tick();
    seg_in[7:0] = 8'hB6;
    repeat (12) tick();
    check("glitch_hex", hex_out[3:0], 4'h3);
    check("glitch_no_update", saw_valid, 1'b0);

    // lane toggling every cycle never locks
    for (int i = 0; i < 20; i++) begin
      seg_in[47:40] = i[0] ? 8'h12 : 8'h7E;
      tick();
    end
    check("toggle_hex", {hex_out[23:20], lane_ok[5]}, {4'hF, 1'b1});
    seg_in[47:40] = 8'hE8;
    repeat (10) tick();
    check("toggle_no_update", saw_valid, 1'b0);

    // dp set on lane2
    upd_ready = 1'b0;
    seg_in[23:16] = 8'h01;
    repeat (LAT + 1) tick();
    check("bad_flags", {bad_pat[2], lane_ok[2], hex_out[11:8]}, {1'b1, 1'b0, 4'hF});
    check("bad_update", {upd_valid, upd_mask[2]}, 2'b11);
    upd_ready = 1'b1;
    tick();
    upd_ready = 1'b0;
    check("no_overrun_yet", {upd_valid, overrun}, 2'b00);

    // backpressure merge of lane0 then lane3
    seg_in[7:0] = 8'hFE;
    repeat (2) tick();
    seg_in[31:24] = 8'h12;
    repeat (LAT + 4) tick();
    check("merge_mask", {upd_valid, upd_mask, overrun}, {1'b1, 8'h09, 1'b1});
    check("merge_hex", {hex_out[15:12], hex_out[3:0]}, 8'h18);
    upd_ready = 1'b1;
    tick();
    upd_ready = 1'b0;
    check("merge_drained", {upd_valid, upd_mask, overrun}, {1'b0, 8'h00, 1'b1});

    // asynchronous reset while an update is pending
    seg_in[15:8] = 8'h12;
    waited = 0;
    while (!upd_valid && waited < 20) begin
      tick();
      waited++;
    end
    check("reset_wait_pend", upd_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset", {hex_out, lane_ok, bad_pat, upd_valid, upd_mask, overrun}, 64'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (LAT - 1) tick();
    check("relock_early", lane_ok, 8'h00);
    tick();
    check("relock", {hex_out, lane_ok, bad_pat}, {32'hFFFF_1018, 8'hFB, 8'h04});

    // randomized traffic against the reference
    upd_ready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        lane = $urandom_range(0, N - 1);
        r = $urandom_range(0, 3);
        if (r < 3) seg_in[8*lane +: 8] = {pat_tab[$urandom_range(0, 15)], 1'b0};
        else       seg_in[8*lane +: 8] = 8'($urandom);
      end
      upd_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
